// File: rtl/seq_divider_if.sv
// Start/busy/done handshake and result bus between the control unit and seq_divider.
interface seq_divider_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             Unsigned;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             div_by_zero;

  modport master (
    output start, a, b, Unsigned,
    input  busy, done, Quotient, Remainder, div_by_zero
  );

  modport slave (
    input  start, a, b, Unsigned,
    output busy, done, Quotient, Remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Iterative radix-2 restoring divider on operand magnitudes with sign fix-up,
// signed or unsigned, one quotient bit per cycle.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         reset,
  seq_divider_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, next_state;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] mag_b;
  logic             sign_a, sign_b;
  logic             done_q;
  logic [WIDTH-1:0] quotient, remainder;
  logic             dbz;

  logic             in_sign_a, in_sign_b;
  logic [WIDTH-1:0] in_mag_a, in_mag_b;
  logic [WIDTH+1:0] shifted, trial;
  logic             trial_neg;

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // DONE lasts two cycles: the first registers done_q, the second shows the pulse.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (bus.start) next_state = (bus.b == '0) ? DONE : RUN;
      RUN:  if (count == LAST) next_state = FIX;
      FIX:  next_state = DONE;
      DONE: if (done_q) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_sign_a = ~bus.Unsigned & bus.a[WIDTH-1];
    in_sign_b = ~bus.Unsigned & bus.b[WIDTH-1];
    in_mag_a  = in_sign_a ? -bus.a : bus.a;
    in_mag_b  = in_sign_b ? -bus.b : bus.b;
    shifted   = {rem, quot[WIDTH-1]};
    trial     = shifted - {2'b00, mag_b};
    trial_neg = trial[WIDTH+1];
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count     <= '0;
      rem       <= '0;
      quot      <= '0;
      mag_b     <= '0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      done_q    <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      dbz       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            sign_a <= in_sign_a;
            sign_b <= in_sign_b;
            quot   <= in_mag_a;
            mag_b  <= in_mag_b;
            rem    <= '0;
            count  <= '0;
            dbz    <= 1'b0;
            if (bus.b == '0) begin
              quotient  <= '0;
              remainder <= bus.a;
              dbz       <= 1'b1;
            end
          end
        end
        RUN: begin
          rem   <= trial_neg ? shifted[WIDTH:0] : trial[WIDTH:0];
          quot  <= {quot[WIDTH-2:0], ~trial_neg};
          count <= count + 1'b1;
        end
        // Remainder follows the dividend's sign so the quotient truncates toward zero.
        FIX: begin
          quotient  <= (sign_a ^ sign_b) ? -quot : quot;
          remainder <= sign_a ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
        end
        DONE: done_q <= ~done_q;
        default: ;
      endcase
    end
  end

  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;
  assign bus.Quotient    = quotient;
  assign bus.Remainder   = remainder;
  assign bus.div_by_zero = dbz;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: table of directed divisions plus
// hand-written handshake and reset sequences.
module tb_seq_divider;
  localparam int WIDTH = 32;

  logic clk = 1'b0;
  logic reset = 1'b0;

  seq_divider_if #(.WIDTH(WIDTH)) bus ();

  seq_divider #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic        uns;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          lat;
    int          busy_n;
  } vec_t;

  vec_t vecs[10];
  int checks = 0;
  int errors = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Called at a negedge; index 0 is the cycle right after the accepting edge.
  task automatic waitDone(input int first, output int lat, output int busy_n,
                          output int done_n);
    lat = -1;
    busy_n = 0;
    done_n = 0;
    for (int i = first; i < first + 100; i++) begin
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (lat < 0) lat = i;
      end
      if (!bus.busy && lat >= 0) break;
      @(negedge clk);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                               input logic uns, output int lat,
                               output int busy_n, output int done_n);
    bus.a        = a;
    bus.b        = b;
    bus.Unsigned = uns;
    bus.start    = 1'b1;
    @(negedge clk);
    bus.start    = 1'b0;
    bus.a        = 32'hDEADBEEF;
    bus.b        = 32'h00000001;
    bus.Unsigned = ~uns;
    waitDone(0, lat, busy_n, done_n);
  endtask

  initial begin
    int lat, busy_n, done_n;

    vecs[0] = '{"u100_7",    32'd100,       32'd7,         1'b1, 32'd14,        32'd2,         1'b0, 34, 35};
    vecs[1] = '{"s_m7_2",    32'hFFFFFFF9,  32'd2,         1'b0, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0, 34, 35};
    vecs[2] = '{"s_7_m2",    32'd7,         32'hFFFFFFFE,  1'b0, 32'hFFFFFFFD,  32'd1,         1'b0, 34, 35};
    vecs[3] = '{"s_min_m1",  32'h80000000,  32'hFFFFFFFF,  1'b0, 32'h80000000,  32'd0,         1'b0, 34, 35};
    vecs[4] = '{"u_min_max", 32'h80000000,  32'hFFFFFFFF,  1'b1, 32'd0,         32'h80000000,  1'b0, 34, 35};
    vecs[5] = '{"u_div0",    32'h12345678,  32'd0,         1'b1, 32'd0,         32'h12345678,  1'b1, 1,  2};
    vecs[6] = '{"s100_7",    32'd100,       32'd7,         1'b0, 32'd14,        32'd2,         1'b0, 34, 35};
    vecs[7] = '{"u_max_16",  32'hFFFFFFFF,  32'd16,        1'b1, 32'h0FFFFFFF,  32'hF,         1'b0, 34, 35};
    vecs[8] = '{"s_m100_m7", 32'hFFFFFF9C,  32'hFFFFFFF9,  1'b0, 32'd14,        32'hFFFFFFFE,  1'b0, 34, 35};
    vecs[9] = '{"s_div0",    32'hFFFFFF00,  32'd0,         1'b0, 32'd0,         32'hFFFFFF00,  1'b1, 1,  2};

    bus.start    = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
    bus.Unsigned = 1'b0;
    reset        = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("reset_done", {31'd0, bus.done}, 32'd0);
    checkOutput("reset_q",    bus.Quotient,      32'd0);
    checkOutput("reset_r",    bus.Remainder,     32'd0);
    checkOutput("reset_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    // Each vector starts in the IDLE cycle that follows the previous done.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].uns, lat, busy_n, done_n);
      checkOutput({vecs[i].name, "_q"},    bus.Quotient,  vecs[i].q);
      checkOutput({vecs[i].name, "_r"},    bus.Remainder, vecs[i].r);
      checkOutput({vecs[i].name, "_dbz"},  {31'd0, bus.div_by_zero}, {31'd0, vecs[i].dbz});
      checkOutput({vecs[i].name, "_lat"},  32'(lat),    32'(vecs[i].lat));
      checkOutput({vecs[i].name, "_busy"}, 32'(busy_n), 32'(vecs[i].busy_n));
      checkOutput({vecs[i].name, "_pulse"}, 32'(done_n), 32'd1);
    end

    // Start pulsed mid-RUN with other operands must be ignored.
    bus.a = 32'd1000; bus.b = 32'd3; bus.Unsigned = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    bus.a = 32'd5; bus.b = 32'd5; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    waitDone(11, lat, busy_n, done_n);
    checkOutput("ignore_q",   bus.Quotient,  32'd333);
    checkOutput("ignore_r",   bus.Remainder, 32'd1);
    checkOutput("ignore_lat", 32'(lat),      32'd34);
    @(negedge clk);
    checkOutput("ignore_idle", {31'd0, bus.busy}, 32'd0);

    // Reset during RUN discards the division.
    bus.a = 32'd100; bus.b = 32'd7; bus.Unsigned = 1'b1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (15) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("midrst_q",    bus.Quotient,      32'd0);
    checkOutput("midrst_r",    bus.Remainder,     32'd0);
    checkOutput("midrst_dbz",  {31'd0, bus.div_by_zero}, 32'd0);
    done_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) done_n++;
    end
    checkOutput("midrst_quiet", 32'(done_n), 32'd0);
    applyStimulus(32'd100, 32'd7, 1'b1, lat, busy_n, done_n);
    checkOutput("after_rst_q",   bus.Quotient,  32'd14);
    checkOutput("after_rst_r",   bus.Remainder, 32'd2);
    checkOutput("after_rst_lat", 32'(lat),      32'd34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
# seq_divider

Iterative 32-bit integer divider supporting signed (SDIV) and unsigned (UDIV) division. It produces quotient and remainder over a fixed multi-cycle sequence using a start/busy/done handshake. It sits beside the datapath ALU so the control unit can stall the pipeline on divide instructions, which keeps the divide out of the single-cycle critical path. It runs radix-2 restoring division on operand magnitudes, then applies sign correction.

## Interface

Parameters:
- WIDTH, 32: operand, quotient and remainder width. Iteration count equals WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- start  in  1  request; sampled only in IDLE.
- a  in  WIDTH  dividend; captured when start is accepted.
- b  in  WIDTH  divisor; captured when start is accepted.
- Unsigned  in  1  1 = unsigned, 0 = two's-complement signed; captured with the operands.
- busy  out  1  high in every state except IDLE.
- done  out  1  single-cycle pulse; the results are valid from this cycle onward.
- Quotient  out  WIDTH  held until the next accepted start.
- Remainder  out  WIDTH  held until the next accepted start.
- div_by_zero  out  1  set with done when b was 0; held until the next accepted start.

## Operation

- States are IDLE, RUN, FIX and DONE.
- **IDLE, start = 1:**
  - Capture the sign of a and the sign of b; both signs are forced to 0 when Unsigned = 1.
  - Load the magnitudes |a| and |b|. Load the quotient register with |a|, the 33-bit partial remainder with 0, and count with 0.
  - Clear div_by_zero.
  - If b == 0, go to DONE, setting Quotient = 0, Remainder = a and div_by_zero = 1. Otherwise go to RUN.
- **RUN, one iteration per cycle:**
  - Shift {rem, quot} left by 1.
  - trial = rem − |b|. If trial ≥ 0, set rem = trial and quot[0] = 1; otherwise quot[0] = 0.
  - count increments each cycle. After the WIDTH-th iteration, go to FIX.
- **FIX:**
  - Quotient = quot, negated if sign_a ^ sign_b.
  - Remainder = rem[WIDTH−1:0], negated if sign_a. The remainder takes the sign of the dividend, so the quotient truncates toward zero.
  - Go to DONE.
- **DONE:** done = 1 for exactly one cycle, then go to IDLE.
- start is ignored whenever busy = 1. There is no queueing and no abort input.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives Quotient = 0x80000000 and Remainder = 0, with no flag raised.
- The magnitude of 0x80000000 is 0x80000000, treated as unsigned. This case needs no special handling.
- A new start may be issued in the cycle immediately after done (the IDLE cycle).

## Timing

- Reset (reset = 0 at an edge) forces the state to IDLE and clears count.
  - Outputs: busy = 0, done = 0, Quotient = 0, Remainder = 0, div_by_zero = 0.
  - This applies in any state, including mid-RUN. The partial result is discarded.
- Let edge E0 be the edge that accepts start. Normal division:
  - E1 to E32: RUN iterations.
  - E33: FIX.
  - E34: registers the DONE state, so done is high in the cycle after E34.
  - E35: returns to IDLE.
  - Latency from start to done is therefore 34 cycles.
- busy goes high in the cycle after E0 and goes low in the cycle after done falls.
- Divide by zero: done is high in the cycle after E1, a latency of 1 cycle.
- Operand inputs may change freely after E0. Only the captured values are used.

## Test plan

- **Unsigned basic:** a = 100, b = 7, Unsigned = 1 → done 34 cycles after start, Quotient = 14, Remainder = 2, div_by_zero = 0, busy high for 35 cycles.
- **Signed sign rules:** a = 0xFFFFFFF9 (−7), b = 2, Unsigned = 0 → Quotient = 0xFFFFFFFD (−3), Remainder = 0xFFFFFFFF (−1). Also a = 7, b = 0xFFFFFFFE → Quotient = 0xFFFFFFFD, Remainder = 1.
- **Extreme operands, same inputs in both modes:** a = 0x80000000, b = 0xFFFFFFFF.
  - Unsigned = 0 → Quotient = 0x80000000, Remainder = 0.
  - Unsigned = 1 → Quotient = 0, Remainder = 0x80000000.
- **Divide by zero:** a = 0x12345678, b = 0 → done 1 cycle after start, Quotient = 0, Remainder = 0x12345678, div_by_zero = 1. The next valid division clears div_by_zero.
- **Handshake:**
  - Pulse start again at cycle 10 of a running divide with different operands → it is ignored and the first result is unchanged.
  - Start in the IDLE cycle right after done → accepted, and the second result arrives 34 cycles later.
- **Reset mid-operation:** drive reset = 0 for one edge at cycle 15 of RUN → the next cycle shows busy = 0, Quotient = 0, Remainder = 0, and no done pulse follows. A subsequent 100 / 7 divide completes normally.
